fpmul_pipe_param: RTL and testbench

Parametrised, fully pipelined IEEE-754-style floating-point multiplier. It is the next generation of the team's fixed fp16 multiplier and is generic in exponent and mantissa width, with fp16 as the default. It adds a valid/ready handshake with whole-pipe backpressure, a runtime rounding-mode select, correctly rounded subnormal outputs, exception flags and a sideband tag. It sits in systolic-array PE datapaths and standalone FP units.

---
 rtl/fpmul_pipe_param.sv | 142 ++++++++++++++
 tb/tb_fpmul_pipe_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_pipe_param.sv
// fpmul_pipe_param: parametrised 3-stage pipelined floating-point multiplier with valid/ready backpressure
//   clk, rst_n (async active-low)          clock and reset
//   in_valid/in_ready, a, b, rnd_mode, tag_in   operand side (rnd_mode 0=RNE, 1=RTZ)
//   out_valid/out_ready, out, flags, tag_out    result side, flags = {invalid, overflow, underflow, inexact}
module fpmul_pipe_param #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   rnd_mode,
  input  logic [TAG_W-1:0]       tag_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic [3:0]             flags,
  output logic [TAG_W-1:0]       tag_out
);
  localparam int S = MAN_W + 1;
  localparam int P = 2 * S;
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 3;
  localparam int EI = EXP_W + $clog2(P) + 4;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam logic [EXP_W-1:0] E_ONES = '1;
  localparam logic [EI-1:0] E_MAX = EI'(2 ** EXP_W - 1);
  localparam logic [W-1:0] QNAN = {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0] INF = {1'b0, E_ONES, {MAN_W{1'b0}}};
  localparam logic [W-1:0] MAXF = {1'b0, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
  logic rdy, advance;
  assign advance = ~out_valid | out_ready;
  assign in_ready = rdy & advance;
  logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff;
  logic [MAN_W-1:0] fa, fb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_snan, b_snan;
  logic [S-1:0] sa, sb;
  assign {ea, fa} = a[W-2:0];
  assign {eb, fb} = b[W-2:0];
  assign a_nan = (ea == E_ONES) & (|fa);
  assign b_nan = (eb == E_ONES) & (|fb);
  assign a_snan = a_nan & ~fa[MAN_W-1];
  assign b_snan = b_nan & ~fb[MAN_W-1];
  assign a_inf = (ea == E_ONES) & ~(|fa);
  assign b_inf = (eb == E_ONES) & ~(|fb);
  assign a_zero = (ea == '0) & ~(|fa);
  assign b_zero = (eb == '0) & ~(|fb);
  // subnormals: implicit bit 0 and effective exponent 1
  assign sa = {|ea, fa};
  assign sb = {|eb, fb};
  assign ea_eff = (ea == '0) ? EXP_W'(1) : ea;
  assign eb_eff = (eb == '0) ? EXP_W'(1) : eb;
  logic v1, sgn1, nan1, inv1, inf1, zero1, rm1;
  logic [TAG_W-1:0] tag1;
  logic [P-1:0] p1;
  logic [EW-1:0] e1;
  logic [EI-1:0] lz, ex, er, neg, shc;
  logic [P-1:0] pn;
  logic [2*P-1:0] x;
  logic tiny;
  // leading-zero count covers both the product-MSB shift and subnormal-input normalisation
  always_comb begin
    lz = '0;
    for (int i = 0; i < P; i++) if (p1[i]) lz = EI'(P - 1 - i);
  end
  assign pn = p1 << lz;
  assign ex = {{(EI-EW){e1[EW-1]}}, e1};
  assign er = ex + EI'(1) - lz;
  assign tiny = er[EI-1] | (er == '0);
  assign neg = EI'(1) - er;
  assign shc = tiny ? ((neg > EI'(P)) ? EI'(P) : neg) : '0;
  // pn sits in the upper half so a right shift of up to P loses nothing from sticky
  assign x = {pn, {P{1'b0}}} >> shc;
  logic v2, sgn2, nan2, inv2, inf2, zero2, rm2, g2, st2, tiny2;
  logic [TAG_W-1:0] tag2;
  logic [S-1:0] m2;
  logic [EI-1:0] ex2;
  logic up, ovf, inx;
  logic [S:0] mr;
  logic [EI-1:0] ef;
  logic [W-1:0] res;
  logic [3:0] fl;
  assign up = ~rm2 & g2 & (st2 | m2[0]);
  assign mr = {1'b0, m2} + (S+1)'(up);
  // subnormal carry into the implicit bit yields exponent 1; normal carry-out bumps the exponent
  assign ef = tiny2 ? EI'(mr[MAN_W]) : ex2 + EI'(mr[S]);
  assign ovf = ef >= E_MAX;
  assign inx = g2 | st2;
  always_comb begin
    res = nan2 ? QNAN : inf2 ? {sgn2, INF[W-2:0]} : zero2 ? {sgn2, {(W-1){1'b0}}} :
          ovf ? {sgn2, (rm2 ? MAXF[W-2:0] : INF[W-2:0])} : {sgn2, ef[EXP_W-1:0], mr[MAN_W-1:0]};
    fl = nan2 ? {inv2, 3'b000} : (inf2 | zero2) ? 4'b0000 : ovf ? 4'b0101 : {2'b00, tiny2 & inx, inx};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      out <= '0;
      flags <= '0;
      tag_out <= '0;
    end else begin
      rdy <= 1'b1;
      if (advance) begin
        v1 <= in_valid & rdy;
        v2 <= v1;
        out_valid <= v2;
        out <= res;
        flags <= fl;
        tag_out <= tag2;
      end
    end
  always_ff @(posedge clk)
    if (advance) begin
      sgn1 <= a[W-1] ^ b[W-1];
      nan1 <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
      inv1 <= a_snan | b_snan | (a_inf & b_zero) | (a_zero & b_inf);
      inf1 <= a_inf | b_inf;
      zero1 <= a_zero | b_zero;
      rm1 <= rnd_mode;
      tag1 <= tag_in;
      p1 <= P'(sa) * P'(sb);
      e1 <= EW'(ea_eff) + EW'(eb_eff) - EW'(BIAS);
      sgn2 <= sgn1;
      nan2 <= nan1;
      inv2 <= inv1;
      inf2 <= inf1;
      zero2 <= zero1;
      rm2 <= rm1;
      tag2 <= tag1;
      m2 <= x[2*P-1 -: S];
      g2 <= x[2*P-1-S];
      st2 <= |x[2*P-2-S:0];
      tiny2 <= tiny;
      ex2 <= tiny ? '0 : er;
    end
endmodule

// File: tb/tb_fpmul_pipe_param.sv
// tb_fpmul_pipe_param: directed and randomised checks of fpmul_pipe_param against an arithmetic fp16 model
module tb_fpmul_pipe_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, in_valid, in_ready, rnd_mode, out_valid, out_ready;
  logic [15:0] a, b, out;
  logic [3:0] flags, tag_in, tag_out;
  logic iv32, ir32, ov32;
  logic [31:0] a32, b32, o32;
  logic [3:0] f32, t32;
  fpmul_pipe_param dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .rnd_mode(rnd_mode), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flags(flags), .tag_out(tag_out));
  fpmul_pipe_param #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .rnd_mode(1'b0), .tag_in(4'd9), .out_valid(ov32), .out_ready(1'b1),
    .out(o32), .flags(f32), .tag_out(t32));
  typedef struct packed {logic [15:0] o; logic [3:0] f; logic [3:0] t;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic hold = 1'b0;
  logic [23:0] held;
  logic use_dir = 1'b0;
  logic [15:0] dir_o;
  logic [3:0] dir_f;
  logic acc;
  logic [52:0] dt [18] = '{
    {16'h3C00, 16'h3C00, 1'b0, 16'h3C00, 4'h0}, {16'h4000, 16'h4200, 1'b0, 16'h4600, 4'h0},
    {16'hC000, 16'h3800, 1'b0, 16'hBC00, 4'h0}, {16'h7C00, 16'h0000, 1'b0, 16'h7E00, 4'h8},
    {16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 4'h8}, {16'hFC00, 16'h4000, 1'b0, 16'hFC00, 4'h0},
    {16'h8000, 16'h3C00, 1'b0, 16'h8000, 4'h0}, {16'h7BFF, 16'h4000, 1'b0, 16'h7C00, 4'h5},
    {16'h7BFF, 16'h4000, 1'b1, 16'h7BFF, 4'h5}, {16'h0003, 16'h3800, 1'b0, 16'h0002, 4'h3},
    {16'h0003, 16'h3800, 1'b1, 16'h0001, 4'h3}, {16'h0001, 16'h3800, 1'b0, 16'h0000, 4'h3},
    {16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'h0}, {16'h03FF, 16'h3C01, 1'b0, 16'h0400, 4'h3},
    {16'h3DA9, 16'h3DA7, 1'b0, 16'h4000, 4'h1}, {16'h3DA9, 16'h3DA7, 1'b1, 16'h3FFF, 4'h1},
    {16'h8001, 16'h3800, 1'b0, 16'h8000, 4'h3}, {16'hFBFF, 16'hC000, 1'b1, 16'h7BFF, 4'h5}};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // fp16 product from exact integer arithmetic: value = m * 2^e, quantised to the result's ulp
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y, input logic rm);
    int ex, ey, e, k, qq, d, msb, expo;
    longint m, r, rem, half;
    logic s, xn, yn, xi, yi, xz, yz, inv, up, inx, tiny;
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    xn = ex == 31 && x[9:0] != 0;
    yn = ey == 31 && y[9:0] != 0;
    xi = ex == 31 && x[9:0] == 0;
    yi = ey == 31 && y[9:0] == 0;
    xz = ex == 0 && x[9:0] == 0;
    yz = ey == 0 && y[9:0] == 0;
    s = x[15] ^ y[15];
    inv = (xn && !x[9]) || (yn && !y[9]) || (xi && yz) || (xz && yi);
    if (xn || yn || (xi && yz) || (xz && yi)) return {inv, 3'b000, 16'h7E00};
    if (xi || yi) return {4'b0000, s, 15'h7C00};
    if (xz || yz) return {4'b0000, s, 15'h0000};
    m = longint'((ex != 0 ? 1024 : 0) + int'(x[9:0])) * longint'((ey != 0 ? 1024 : 0) + int'(y[9:0]));
    e = (ex != 0 ? ex : 1) + (ey != 0 ? ey : 1) - 50;
    msb = 0;
    for (int i = 0; i < 40; i++) if (m[i]) msb = i;
    k = e + msb;
    qq = (k - 10 < -24) ? -24 : k - 10;
    tiny = k < -14;
    d = qq - e;
    if (d <= 0) begin
      r = m << (-d);
      rem = 0;
      half = 1;
    end else begin
      r = m >> d;
      rem = m & ((64'sd1 << d) - 1);
      half = 64'sd1 << (d - 1);
    end
    inx = rem != 0;
    up = !rm && (rem > half || (rem == half && r[0]));
    r = r + longint'(up);
    if (r == 2048) begin
      r = 1024;
      qq++;
    end
    expo = (r >= 1024) ? qq + 25 : 0;
    if (expo >= 31) return rm ? {4'b0101, s, 15'h7BFF} : {4'b0101, s, 15'h7C00};
    return {2'b00, tiny && inx, inx, s, 5'(expo), r[9:0]};
  endfunction

  function automatic logic [15:0] rnd16();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom % 2 == 0) v[14:10] = 5'($urandom_range(8, 22));
    else if ($urandom % 4 == 0) v[14:10] = 5'($urandom_range(0, 3));
    return v;
  endfunction

  // called at a falling edge; samples the handshake, scores outputs, then advances one clock
  task automatic cycle(output logic accepted);
    exp_t e;
    logic [19:0] r;
    #1;
    if (hold) chk("stable_hold", 64'({out_valid, out, flags, tag_out}), 64'({1'b1, held}));
    if (out_valid && !out_ready) chk("in_ready_low_on_stall", 64'(in_ready), 64'(0));
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'(0));
      else begin
        e = q.pop_front();
        chk("result", 64'({out, flags, tag_out}), 64'(e));
      end
    end
    accepted = in_valid & in_ready;
    if (accepted) begin
      r = model(a, b, rnd_mode);
      q.push_back(use_dir ? {dir_o, dir_f, tag_in} : {r[15:0], r[19:16], tag_in});
    end
    hold = out_valid & ~out_ready;
    held = {out, flags, tag_out};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      cycle(acc);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic [35:0] expv);
    int n;
    iv32 = 1'b1;
    a32 = x;
    b32 = y;
    #1 chk("in_ready32", 64'(ir32), 64'(1));
    @(negedge clk);
    iv32 = 1'b0;
    n = 0;
    while (!ov32 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("fp32_valid", 64'(ov32), 64'(1));
    chk("fp32_result", 64'({t32, f32, o32}), 64'({4'd9, expv}));
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat, n, cnt, idx;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    rnd_mode = 1'b0;
    tag_in = '0;
    iv32 = 1'b0;
    a32 = '0;
    b32 = '0;
    repeat (2) @(negedge clk);
    #1 chk("reset_outputs", 64'({out_valid, out, flags, tag_out}), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("in_ready_after_edge", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 16'h3C00;
    b = 16'h3C00;
    tag_in = 4'd1;
    cycle(acc);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      cycle(acc);
      lat++;
    end
    chk("latency", 64'(lat), 64'(3));
    drain();
    use_dir = 1'b1;
    for (int i = 0; i < 18; i++) begin
      {a, b, rnd_mode, dir_o, dir_f} = dt[i];
      tag_in = 4'(i);
      in_valid = 1'b1;
      cycle(acc);
      chk("directed_accept", 64'(acc), 64'(1));
    end
    drain();
    use_dir = 1'b0;
    n = 0;
    cnt = 0;
    while (n < 300 && cnt < 3000) begin
      in_valid = ($urandom % 5) != 0;
      a = rnd16();
      b = rnd16();
      rnd_mode = 1'($urandom);
      tag_in = 4'($urandom);
      out_ready = ($urandom % 4) != 0;
      cycle(acc);
      n += int'(acc);
      cnt++;
    end
    chk("random_ops_issued", 64'(n), 64'(300));
    drain();
    idx = 0;
    cnt = 0;
    while ((idx < 8 || q.size() > 0) && cnt < 80) begin
      in_valid = idx < 8;
      a = rnd16();
      b = rnd16();
      rnd_mode = 1'($urandom);
      tag_in = 4'(idx);
      out_ready = (cnt >= 3 && cnt < 8) ? 1'b0 : 1'($urandom);
      cycle(acc);
      idx += int'(acc);
      cnt++;
    end
    chk("bp_all_issued", 64'(idx), 64'(8));
    drain();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = rnd16();
      b = rnd16();
      tag_in = 4'(i);
      cycle(acc);
    end
    in_valid = 1'b0;
    chk("pre_reset_out_valid", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 64'({out_valid, out, flags, tag_out}), 64'(0));
    chk("async_reset_in_ready", 64'(in_ready), 64'(0));
    q.delete();
    hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_held_after_release", 64'(in_ready), 64'(0));
    @(negedge clk);
    chk("in_ready_after_release", 64'(in_ready), 64'(1));
    for (int i = 0; i < 6; i++) begin
      chk("no_stale_result", 64'(out_valid), 64'(0));
      cycle(acc);
    end
    run32(32'h3F800000, 32'h40400000, {4'h0, 32'h40400000});
    run32(32'h40000000, 32'h40400000, {4'h0, 32'h40C00000});
    run32(32'h7F800000, 32'h00000000, {4'h8, 32'h7FC00000});
    run32(32'h00000001, 32'h3F000000, {4'h3, 32'h00000000});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
